// File: rtl/osd_regaccess_demux.sv
// Register-port demultiplexer: routes one debug register transfer at a time to an address-decoded
// slave bank, terminating decode misses and silent slaves with an error response.
module osd_regaccess_demux #(
  parameter int NUM_SLAVES = 2,
  parameter int WIN_BITS   = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_request,
  input  logic                      m_write,
  input  logic [15:0]               m_addr,
  input  logic [1:0]                m_size,
  input  logic [15:0]               m_wdata,
  output logic                      m_ack,
  output logic                      m_err,
  output logic [15:0]               m_rdata,
  output logic [NUM_SLAVES-1:0]     s_request,
  output logic                      s_write,
  output logic [15:0]               s_addr,
  output logic [1:0]                s_size,
  output logic [15:0]               s_wdata,
  input  logic [NUM_SLAVES-1:0]     s_ack,
  input  logic [NUM_SLAVES-1:0]     s_err,
  input  logic [16*NUM_SLAVES-1:0]  s_rdata,
  output logic [7:0]                err_count
);
  localparam int PW = 16 - WIN_BITS;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_RESP, ST_WAIT_DROP} state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic [TW-1:0]   r_timer;

  logic [PW-1:0]         w_page;
  logic [PW-1:0]         w_idx;
  logic                  w_dec_err;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_sel_ack;
  logic                  w_sel_err;
  logic [15:0]           w_sel_rdata;
  logic                  w_timeout;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Window 0 is the register access block's own local range, so slave i lives at page i+1.
  assign w_page      = m_addr[15:WIN_BITS];
  assign w_idx       = w_page - PW'(1);
  assign w_dec_err   = (w_page == '0) || (32'(w_idx) >= NUM_SLAVES);
  assign w_onehot    = NUM_SLAVES'(1) << w_idx;
  assign w_sel_ack   = s_ack[r_sel];
  assign w_sel_err   = s_err[r_sel];
  assign w_sel_rdata = s_rdata[16*r_sel +: 16];
  assign w_timeout   = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_timer   <= '0;
      m_ack     <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      s_request <= '0;
      s_write   <= 1'b0;
      s_addr    <= '0;
      s_size    <= '0;
      s_wdata   <= '0;
      err_count <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_request) begin
            s_write <= m_write;
            s_addr  <= m_addr;
            s_size  <= m_size;
            s_wdata <= m_wdata;
            if (w_dec_err) begin
              m_err     <= 1'b1;
              m_rdata   <= '0;
              err_count <= sat_inc(err_count);
              r_state   <= ST_RESP;
            end else begin
              r_sel     <= SW'(w_idx);
              r_timer   <= '0;
              s_request <= w_onehot;
              r_state   <= ST_FWD;
            end
          end
        end
        ST_FWD: begin
          // A slave error takes priority over a simultaneous ack and is not counted locally.
          if (w_sel_ack || w_sel_err) begin
            m_rdata   <= w_sel_rdata;
            m_err     <= w_sel_err;
            m_ack     <= !w_sel_err;
            s_request <= '0;
            r_state   <= ST_RESP;
          end else if (w_timeout) begin
            m_err     <= 1'b1;
            m_rdata   <= '0;
            err_count <= sat_inc(err_count);
            s_request <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: r_state <= ST_WAIT_DROP;
        ST_WAIT_DROP: begin
          if (!m_request) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_regaccess_demux.sv
// Bench for osd_regaccess_demux: two instances (long and short timeout) sharing stimulus,
// response expectations queued at stimulus time and popped when the selected instance answers.
module tb_osd_regaccess_demux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_request, m_write;
  logic [15:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  logic [1:0]  s_ack, s_err;
  logic [31:0] s_rdata;
  bit          use_b;

  logic        req_a, req_b;
  logic        ack_a, err_a, swr_a, ack_b, err_b, swr_b;
  logic [15:0] rdata_a, saddr_a, swdata_a, rdata_b, saddr_b, swdata_b;
  logic [1:0]  sreq_a, ssize_a, sreq_b, ssize_b;
  logic [7:0]  ecnt_a, ecnt_b;

  logic        ack, err, swr;
  logic [15:0] rdata, saddr, swdata;
  logic [1:0]  sreq;
  logic [7:0]  ecnt;

  logic [16:0] sb_q[$];
  logic [16:0] exp_r;
  int          exp_cnt_a, exp_cnt_b;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign req_a  = m_request & ~use_b;
  assign req_b  = m_request & use_b;
  assign ack    = use_b ? ack_b : ack_a;
  assign err    = use_b ? err_b : err_a;
  assign swr    = use_b ? swr_b : swr_a;
  assign rdata  = use_b ? rdata_b : rdata_a;
  assign saddr  = use_b ? saddr_b : saddr_a;
  assign swdata = use_b ? swdata_b : swdata_a;
  assign sreq   = use_b ? sreq_b : sreq_a;
  assign ecnt   = use_b ? ecnt_b : ecnt_a;

  osd_regaccess_demux #(.NUM_SLAVES(2), .WIN_BITS(9), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .m_request(req_a), .m_write(m_write), .m_addr(m_addr),
    .m_size(m_size), .m_wdata(m_wdata), .m_ack(ack_a), .m_err(err_a), .m_rdata(rdata_a),
    .s_request(sreq_a), .s_write(swr_a), .s_addr(saddr_a), .s_size(ssize_a), .s_wdata(swdata_a),
    .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata), .err_count(ecnt_a));

  osd_regaccess_demux #(.NUM_SLAVES(2), .WIN_BITS(9), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .m_request(req_b), .m_write(m_write), .m_addr(m_addr),
    .m_size(m_size), .m_wdata(m_wdata), .m_ack(ack_b), .m_err(err_b), .m_rdata(rdata_b),
    .s_request(sreq_b), .s_write(swr_b), .s_addr(saddr_b), .s_size(ssize_b), .s_wdata(swdata_b),
    .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata), .err_count(ecnt_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (ack || err) begin
        got = 1'b1;
        return;
      end
      step();
    end
    got = ack || err;
  endtask

  task automatic release_req();
    m_request = 1'b0;
    s_ack = '0;
    s_err = '0;
    step(); step(); step();
  endtask

  task automatic pop_exp(output logic [16:0] e);
    if (sb_q.size() == 0) e = 17'h1_FFFF;
    else e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_request = 0; m_write = 0; m_addr = '0; m_size = '0; m_wdata = '0;
    s_ack = '0; s_err = '0; s_rdata = '0; use_b = 0;
    step(); step(); step();
    n_cmp++; if (sreq !== 2'b00) begin n_fail++; $display("FAIL rst_sreq got=%b exp=00", sreq); end
    n_cmp++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_ackerr got=%b%b exp=00", ack, err); end
    n_cmp++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
    n_cmp++; if (ecnt !== 8'h0) begin n_fail++; $display("FAIL rst_ecnt got=%h exp=00", ecnt); end
    n_cmp++; if (saddr !== 16'h0) begin n_fail++; $display("FAIL rst_saddr got=%h exp=0000", saddr); end
    n_cmp++; if (ecnt_b !== 8'h0) begin n_fail++; $display("FAIL rst_ecnt_b got=%h exp=00", ecnt_b); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    use_b = 0;
    m_request = 1; m_write = 0; m_addr = 16'h0205; m_size = 2'b01;
    sb_q.push_back({1'b0, 16'hBEEF});
    step();
    n_cmp++; if (sreq !== 2'b01) begin n_fail++; $display("FAIL rd_sreq got=%b exp=01", sreq); end
    n_cmp++; if (saddr !== 16'h0205) begin n_fail++; $display("FAIL rd_saddr got=%h exp=0205", saddr); end
    s_ack = 2'b01; s_rdata = {16'h1111, 16'hBEEF};
    step();
    n_cmp++; if (ack !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL rd_ack got=%b%b exp=10", ack, err); end
    pop_exp(exp_r);
    n_cmp++; if ({err, rdata} !== exp_r) begin n_fail++; $display("FAIL rd_resp got=%h exp=%h", {err, rdata}, exp_r); end
    s_ack = '0;
    step();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got=%b exp=0", ack); end
    n_cmp++; if (ecnt !== 8'(exp_cnt_a)) begin n_fail++; $display("FAIL rd_ecnt got=%0d exp=%0d", ecnt, exp_cnt_a); end
    release_req();
  endtask

  task automatic test_write();
    bit got;
    use_b = 0;
    m_request = 1; m_write = 1; m_addr = 16'h0410; m_wdata = 16'h1234; m_size = 2'b00;
    s_rdata = {16'h5555, 16'h9999};
    sb_q.push_back({1'b0, 16'h5555});
    step();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (sreq !== 2'b10 || swdata !== 16'h1234 || ack !== 1'b0)
        begin n_fail++; $display("FAIL wr_hold%0d got sreq=%b wdata=%h ack=%b exp 10/1234/0", k, sreq, swdata, ack); end
      m_wdata = 16'hFFFF;
      step();
    end
    s_ack = 2'b10;
    wait_resp(4, got);
    n_cmp++; if (!got || ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack got=%b exp=1", ack); end
    n_cmp++; if (swr !== 1'b1) begin n_fail++; $display("FAIL wr_swrite got=%b exp=1", swr); end
    pop_exp(exp_r);
    n_cmp++; if ({err, rdata} !== exp_r) begin n_fail++; $display("FAIL wr_resp got=%h exp=%h", {err, rdata}, exp_r); end
    step();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_single got=%b exp=0", ack); end
    release_req();
  endtask

  task automatic test_decode_err();
    logic [15:0] addrs [2];
    addrs[0] = 16'h0003;
    addrs[1] = 16'h0600;
    use_b = 0;
    s_rdata = {16'hAAAA, 16'hBBBB};
    for (int i = 0; i < 2; i++) begin
      m_request = 1; m_write = 0; m_addr = addrs[i];
      sb_q.push_back({1'b1, 16'h0000});
      exp_cnt_a++;
      step();
      n_cmp++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL dec%0d_err got=%b%b exp=01", i, ack, err); end
      n_cmp++; if (sreq !== 2'b00) begin n_fail++; $display("FAIL dec%0d_sreq got=%b exp=00", i, sreq); end
      pop_exp(exp_r);
      n_cmp++; if ({err, rdata} !== exp_r) begin n_fail++; $display("FAIL dec%0d_resp got=%h exp=%h", i, {err, rdata}, exp_r); end
      release_req();
      n_cmp++; if (ecnt !== 8'(exp_cnt_a)) begin n_fail++; $display("FAIL dec%0d_ecnt got=%0d exp=%0d", i, ecnt, exp_cnt_a); end
    end
  endtask

  task automatic test_timeout();
    use_b = 1;
    s_rdata = {16'h7777, 16'h3333};
    m_request = 1; m_write = 0; m_addr = 16'h0205;
    sb_q.push_back({1'b1, 16'h0000});
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (sreq !== 2'b01 || err !== 1'b0 || ack !== 1'b0)
        begin n_fail++; $display("FAIL to_fwd%0d got sreq=%b ack=%b err=%b exp 01/0/0", k, sreq, ack, err); end
      if (k == 1) s_ack = 2'b10;
      step();
    end
    exp_cnt_b++;
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0 || sreq !== 2'b00)
      begin n_fail++; $display("FAIL to_err got sreq=%b ack=%b err=%b exp 00/0/1", sreq, ack, err); end
    pop_exp(exp_r);
    n_cmp++; if ({err, rdata} !== exp_r) begin n_fail++; $display("FAIL to_resp got=%h exp=%h", {err, rdata}, exp_r); end
    s_ack = 2'b01;
    step(); step();
    n_cmp++; if (ack !== 1'b0 || err !== 1'b0 || sreq !== 2'b00)
      begin n_fail++; $display("FAIL to_late got sreq=%b ack=%b err=%b exp 00/0/0", sreq, ack, err); end
    n_cmp++; if (ecnt !== 8'(exp_cnt_b)) begin n_fail++; $display("FAIL to_ecnt got=%0d exp=%0d", ecnt, exp_cnt_b); end
    release_req();
    use_b = 0;
  endtask

  task automatic test_slave_err_held();
    use_b = 0;
    m_request = 1; m_write = 0; m_addr = 16'h0205;
    sb_q.push_back({1'b1, 16'hDEAD});
    step();
    s_err = 2'b01; s_ack = 2'b01; s_rdata = {16'h0000, 16'hDEAD};
    step();
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0) begin n_fail++; $display("FAIL serr_err got=%b%b exp=01", ack, err); end
    pop_exp(exp_r);
    n_cmp++; if ({err, rdata} !== exp_r) begin n_fail++; $display("FAIL serr_resp got=%h exp=%h", {err, rdata}, exp_r); end
    s_err = '0; s_ack = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (sreq !== 2'b00 || ack !== 1'b0 || err !== 1'b0)
        begin n_fail++; $display("FAIL held%0d got sreq=%b ack=%b err=%b exp 00/0/0", k, sreq, ack, err); end
    end
    n_cmp++; if (ecnt !== 8'(exp_cnt_a)) begin n_fail++; $display("FAIL serr_ecnt got=%0d exp=%0d", ecnt, exp_cnt_a); end
    m_request = 0;
    step();
    m_request = 1;
    sb_q.push_back({1'b0, 16'hABCD});
    s_rdata = {16'h0000, 16'hABCD};
    step();
    n_cmp++; if (sreq !== 2'b01) begin n_fail++; $display("FAIL rereq_sreq got=%b exp=01", sreq); end
    s_ack = 2'b01;
    step();
    pop_exp(exp_r);
    n_cmp++; if (ack !== 1'b1 || {err, rdata} !== exp_r) begin n_fail++; $display("FAIL rereq_resp ack=%b got=%h exp=%h", ack, {err, rdata}, exp_r); end
    release_req();
  endtask

  task automatic test_reset_mid();
    use_b = 0;
    m_request = 1; m_write = 0; m_addr = 16'h0205;
    step();
    n_cmp++; if (sreq !== 2'b01) begin n_fail++; $display("FAIL rmid_pre got=%b exp=01", sreq); end
    rst_n = 1'b0;
    #1;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    n_cmp++; if (sreq !== 2'b00 || ack !== 1'b0 || err !== 1'b0)
      begin n_fail++; $display("FAIL rmid_async got sreq=%b ack=%b err=%b exp 00/0/0", sreq, ack, err); end
    n_cmp++; if (ecnt !== 8'(exp_cnt_a)) begin n_fail++; $display("FAIL rmid_ecnt got=%0d exp=%0d", ecnt, exp_cnt_a); end
    m_request = 0;
    step();
    rst_n = 1'b1;
    step();
    m_request = 1;
    sb_q.push_back({1'b0, 16'hCAFE});
    s_rdata = {16'h0000, 16'hCAFE};
    step();
    n_cmp++; if (sreq !== 2'b01) begin n_fail++; $display("FAIL rmid_sreq got=%b exp=01", sreq); end
    s_ack = 2'b01;
    step();
    pop_exp(exp_r);
    n_cmp++; if (ack !== 1'b1 || {err, rdata} !== exp_r) begin n_fail++; $display("FAIL rmid_resp ack=%b got=%h exp=%h", ack, {err, rdata}, exp_r); end
    release_req();
  endtask

  initial begin
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_timeout();
    test_slave_err_held();
    test_reset_mid();
    n_cmp++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
